pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register, the successor to the fixed-field stage registers between EX/MEM and MEM/WB. It carries an opaque payload bus and a control-bit bus through a valid/ready handshake, supports back-pressure (stall) and flush (bubble insertion), and keeps saturating stall/bubble counters for performance debug. One instance sits on each stage boundary of the pipelined core.

## Interface
- DATA_W, 192, payload width (PC, ALU result, store data, branch target, funct, rd packed by the instantiating stage)
- CTRL_W, 6, control-bit width (RegWrite, MemWrite, Branch, ZERO, MemtoReg, MemRead); cleared on flush
- CNT_W, 16, width of each performance counter

- clk  in  1  clock; all state captured on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  this register accepts an entry this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream consumes the entry this cycle
- out_data  out  DATA_W  registered payload
- out_ctrl  out  CTRL_W  registered control bits; all-zero whenever out_valid=0
- flush  in  1  synchronous kill of all held and incoming entries
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0

## Operation
- Accept: in_valid & in_ready. Emit: out_valid & out_ready.
- Base mode (single entry): in_ready = ~out_valid | out_ready (combinational). On accept, out_data/out_ctrl load inputs, out_valid=1. On emit without accept, out_valid=0, out_ctrl=0. Simultaneous emit+accept: new entry replaces old, out_valid stays 1.
- out_ctrl is forced to zero whenever out_valid=0 so a bubble can never write registers or memory; out_data holds its last value (don't-care).
- Flush: at the next edge all held entries are discarded, out_valid=0, out_ctrl=0, and any same-cycle input is dropped even if accepted by handshake. Flush dominates accept and emit.
- Counters: stall_cnt increments each cycle out_valid & ~out_ready; bubble_cnt increments each cycle ~out_valid. Both saturate at 2^CNT_W-1 and hold. Flush does not clear them; only reset does.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, bubble_cnt=0, skid entry empty; in_ready=1 in both modes.
- Latency: accepted entry visible on out_* one cycle after the accepting edge, in both modes.
- Throughput: one entry per cycle while out_ready=1.
- Reset asserted mid-transfer aborts it; no entry survives reset.
- Deassertion of rst_n is synchronised externally; the block requires only that no handshake is asserted in the deassertion cycle.

## Configuration
- PIPE_SKID_EN defined: two-entry (main + skid) buffer. in_ready = ~skid_valid, driven from a flop, so no combinational path from out_ready to in_ready. If main is full and out_ready=0, an accepted entry goes to skid; when main empties, skid moves to main the same edge. Full (both valid) -> in_ready=0. Ordering strictly FIFO. Flush empties both.
- Undefined: base single-entry mode above; no skid storage is instantiated.

## Test plan
- Reset: rst_n low mid-stream with out_valid=1 -> out_valid, out_ctrl, counters read 0 immediately, in_ready=1 after release.
- Streaming: 8 entries, in_data=0x1..0x8, out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, each one cycle after accept, bubble_cnt unchanged during the burst.
- Back-pressure: load 0xA, hold out_ready=0 for 5 cycles -> out_data=0xA held, stall_cnt +5; base mode in_ready=0 throughout; PIPE_SKID_EN accepts 0xB once then in_ready=0, releasing yields 0xA then 0xB.
- Flush: held entry ctrl=6'b111111 plus in_valid=1 with flush=1 -> next cycle out_valid=0, out_ctrl=0, neither entry ever emitted.
- Saturation: CNT_W=4, out_valid=0 for 20 cycles -> bubble_cnt stops at 15.
- Simultaneous emit+accept (base mode, out_ready=1, in_valid=1, data 0xC over 0xB) -> out_data=0xC next cycle, out_valid stays 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and saturating stall/bubble counters.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 192,
   parameter int unsigned CTRL_W = 6,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic              accept;
   logic              main_free;

   assign main_free = ~main_valid_q | out_ready;
   assign accept    = in_valid & in_ready;

`ifdef PIPE_SKID_EN
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

   // in_ready comes straight from a flop: no combinational path from out_ready.
   assign in_ready = ~skid_valid_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_ctrl_d  = '0;
         skid_valid_d = 1'b0;
         skid_ctrl_d  = '0;
      end else if (main_free) begin
         if (skid_valid_q) begin
            // Skid is older than anything arriving now; an accept cannot coincide (in_ready=0).
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
         end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
         end else begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
         skid_ctrl_d  = in_ctrl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
      end
   end

   // NOTE: skid payload needs no reset; it is never observed while skid_valid_q is low.
   always_ff @(posedge clk) begin
      skid_data_q <= skid_data_d;
   end
`else
   logic emit;

   assign in_ready = main_free;
   assign emit     = main_valid_q & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_ctrl_d  = '0;
      end else if (accept) begin
         main_valid_d = 1'b1;
         main_data_d  = in_data;
         main_ctrl_d  = in_ctrl;
      end else if (emit) begin
         main_valid_d = 1'b0;
         main_ctrl_d  = '0;
      end
   end
`endif

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (!main_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ctrl_q  <= '0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign out_valid  = main_valid_q;
   assign out_data   = main_data_q;
   assign out_ctrl   = main_ctrl_q;
   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; builds with or without PIPE_SKID_EN.
module tb_pipe_stage_reg;

   localparam int DW   = 192;
   localparam int CW   = 6;
   localparam int CNTW = 16;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
   } entry_t;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic [CW-1:0]   in_ctrl;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic [CW-1:0]   out_ctrl;
   logic            flush;
   logic [CNTW-1:0] stall_cnt;
   logic [CNTW-1:0] bubble_cnt;

   logic            sat_rst_n;
   logic            sat_in_ready;
   logic            sat_out_valid;
   logic [7:0]      sat_out_data;
   logic [CW-1:0]   sat_out_ctrl;
   logic [3:0]      sat_stall_cnt;
   logic [3:0]      sat_bubble_cnt;

   int     n_checks;
   int     n_fail;
   entry_t sb[$];

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(CNTW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ctrl   (out_ctrl),
      .flush      (flush),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   pipe_stage_reg #(.DATA_W(8), .CTRL_W(CW), .CNT_W(4)) dut_sat (
      .clk        (clk),
      .rst_n      (sat_rst_n),
      .in_valid   (1'b0),
      .in_ready   (sat_in_ready),
      .in_data    (8'h00),
      .in_ctrl    ({CW{1'b0}}),
      .out_valid  (sat_out_valid),
      .out_ready  (1'b0),
      .out_data   (sat_out_data),
      .out_ctrl   (sat_out_ctrl),
      .flush      (1'b0),
      .stall_cnt  (sat_stall_cnt),
      .bubble_cnt (sat_bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: inputs change just after posedge, so negedge sees the values the next edge will use.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (!out_valid) check("bubble_ctrl_zero", 200'(out_ctrl), 200'(0));
         if (flush) begin
            sb.delete();
         end else begin
            if (out_valid && out_ready) begin
               check("sb_nonempty_on_emit", 200'(sb.size() != 0), 200'(1));
               if (sb.size() != 0) begin
                  entry_t e;
                  e = sb.pop_front();
                  check("emit_data", 200'(out_data), 200'(e.data));
                  check("emit_ctrl", 200'(out_ctrl), 200'(e.ctrl));
               end
            end
            if (in_valid && in_ready) sb.push_back('{data: in_data, ctrl: in_ctrl});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      sat_rst_n = 1'b0;

      // Reset mid-stream with a held entry.
      do_reset();
      check("rst_in_ready_idle", 200'(in_ready), 200'(1));
      in_valid = 1'b1; in_data = DW'(64'h55); in_ctrl = 6'h2A;
      step();
      in_valid = 1'b0;
      check("pre_rst_valid", 200'(out_valid), 200'(1));
      step();
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 200'(out_valid), 200'(0));
      check("rst_out_ctrl", 200'(out_ctrl), 200'(0));
      check("rst_out_data", 200'(out_data), 200'(0));
      check("rst_stall_cnt", 200'(stall_cnt), 200'(0));
      check("rst_bubble_cnt", 200'(bubble_cnt), 200'(0));
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready_after", 200'(in_ready), 200'(1));

      // Streaming 0x1..0x8 with out_ready held high.
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i);
         step();
         check("stream_valid", 200'(out_valid), 200'(1));
         check("stream_data", 200'(out_data), 200'(i));
         check("stream_ctrl", 200'(out_ctrl), 200'(i));
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", 200'(out_valid), 200'(0));
      check("stream_bubble_cnt", 200'(bubble_cnt), 200'(1));
      check("stream_stall_cnt", 200'(stall_cnt), 200'(0));
      check("stream_sb_empty", 200'(sb.size()), 200'(0));

      // Back-pressure: 0xA held for 5 stalled cycles, 0xB offered behind it.
      do_reset();
      in_valid = 1'b1; in_data = DW'(64'hA); in_ctrl = 6'h01;
      step();
      check("bp_valid_a", 200'(out_valid), 200'(1));
      check("bp_data_a", 200'(out_data), 200'(64'hA));
      in_data = DW'(64'hB); in_ctrl = 6'h02;
`ifdef PIPE_SKID_EN
      check("bp_in_ready_skid_free", 200'(in_ready), 200'(1));
`else
      check("bp_in_ready_base", 200'(in_ready), 200'(0));
`endif
      for (int k = 0; k < 5; k++) begin
         step();
`ifdef PIPE_SKID_EN
         in_valid = 1'b0;
`endif
         check("bp_hold_valid", 200'(out_valid), 200'(1));
         check("bp_hold_data", 200'(out_data), 200'(64'hA));
         check("bp_in_ready_full", 200'(in_ready), 200'(0));
      end
      check("bp_stall_cnt", 200'(stall_cnt), 200'(5));
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("bp_valid_b", 200'(out_valid), 200'(1));
      check("bp_data_b", 200'(out_data), 200'(64'hB));
      check("bp_in_ready_release", 200'(in_ready), 200'(1));
      step();
      check("bp_drained", 200'(out_valid), 200'(0));
      check("bp_stall_cnt_final", 200'(stall_cnt), 200'(5));
      check("bp_sb_empty", 200'(sb.size()), 200'(0));

      // Flush kills a held all-ones-ctrl entry and a same-cycle input.
      do_reset();
      in_valid = 1'b1; in_data = DW'(64'hD); in_ctrl = 6'h3F;
      step();
      check("fl_loaded", 200'(out_ctrl), 200'(6'h3F));
      in_data = DW'(64'hE); in_ctrl = 6'h3F; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("fl_valid", 200'(out_valid), 200'(0));
      check("fl_ctrl", 200'(out_ctrl), 200'(0));
      for (int k = 0; k < 3; k++) begin
         step();
         check("fl_no_emit", 200'(out_valid), 200'(0));
      end

      // Simultaneous emit and accept: 0xC replaces 0xB.
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = DW'(64'hB); in_ctrl = 6'h11;
      step();
      in_data = DW'(64'hC); in_ctrl = 6'h22;
      step();
      in_valid = 1'b0;
      check("sim_valid", 200'(out_valid), 200'(1));
      check("sim_data", 200'(out_data), 200'(64'hC));
      check("sim_ctrl", 200'(out_ctrl), 200'(6'h22));
      step();
      check("sim_drained", 200'(out_valid), 200'(0));
      check("sim_sb_empty", 200'(sb.size()), 200'(0));

      // Saturation on the 4-bit-counter instance.
      step();
      sat_rst_n = 1'b1;
      repeat (5) step();
      check("sat_bubble_5", 200'(sat_bubble_cnt), 200'(5));
      repeat (10) step();
      check("sat_bubble_15", 200'(sat_bubble_cnt), 200'(15));
      repeat (5) step();
      check("sat_bubble_hold", 200'(sat_bubble_cnt), 200'(15));
      check("sat_stall_zero", 200'(sat_stall_cnt), 200'(0));
      check("sat_valid_zero", 200'(sat_out_valid), 200'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
